apb_irq_ctrl: RTL and testbench
===============================

// Module: apb_irq_ctrl
// PURPOSE
//  Downstream consumer of the apb_timer irq_o bus (2 lines per timer: overflow, compare).
//  Catches each timer pulse as a sticky pending bit, applies a per-line mask, and drives
//  one CPU interrupt plus the winning line ID. APB slave for software pending/mask/clear.
// PARAMETERS
//  IRQ_NUM  4  number of interrupt inputs (TIM_NUM*2); legal range 1..32
// PORTS
//  pclk     in   1        clock; all state on rising edge
//  preset   in   1        synchronous, active-high reset
//  paddr    in   32       APB address; registers decoded from paddr[4:2]
//  psel     in   1        APB select
//  penable  in   1        APB access phase
//  pwrite   in   1        APB write
//  pwdata   in   32       APB write data
//  prdata   out  32       APB read data
//  pready   out  1        tied 1 (zero wait states)
//  pslverr  out  1        tied 0
//  irq_i    in   IRQ_NUM  interrupt sources (timer irq_o; single-cycle pulses or levels)
//  irq_o    out  1        CPU interrupt, level: |(pending & mask)
//  irq_id_o out  5        index of lowest-numbered pending&enabled line; 0 when irq_o=0
// BEHAVIOUR
//  Reset (preset=1 at pclk edge): pending=0, mask=0, irq_prev=0, type=0 -> irq_o=0,
//    irq_id_o=0, prdata=0. Reset mid-transfer aborts it; no write is taken.
//  Register map (32b, bits >= IRQ_NUM read 0, write ignored):
//    0x00 PENDING  RO  sticky pending bits
//    0x04 MASK     RW  1 = line enabled
//    0x08 CLEAR    WO  write-1-to-clear pending; reads 0
//    0x0C ID       RO  [31]=irq_o, [4:0]=irq_id_o
//    0x10 TYPE     RW  only with IRQ_CTRL_TYPE_EN (else unmapped)
//    Unmapped: reads 0, writes ignored, pslverr stays 0.
//  APB: write commits on the pclk edge where psel&penable&pwrite=1. prdata is
//    combinational, valid when psel&penable&!pwrite, else 0. Reads have no side effects.
//  Edge detect: irq_prev <= irq_i every cycle; rise[i] = irq_i[i] & ~irq_prev[i].
//    A line high on the first cycle after reset counts as a rising edge.
//  Pending update per bit: pending_n = (pending & ~clr) | set; set = rise (edge mode).
//    Set and CLEAR on the same bit in the same cycle: set wins, no event lost.
//    Pending bits record independently of MASK; unmasking a pending bit raises irq_o
//    in the cycle after the MASK write.
//  Latency: irq_i rises in cycle N -> pending and irq_o high in cycle N+1
//    (irq_o/irq_id_o are combinational from pending_q & mask_q; no extra stage).
//  Priority: fixed, lowest index wins; irq_id_o updates same cycle as pending/mask.
//  Back-to-back pulses on a line before clear collapse into one pending bit.
// CONFIGURATION
//  IRQ_CTRL_TYPE_EN defined: TYPE register at 0x10; TYPE[i]=1 makes line i
//    level-sensitive: set[i]=irq_i[i] every cycle, so CLEAR of a still-high line
//    re-pends next cycle. TYPE[i]=0 keeps edge mode.
//  Not defined: no TYPE register (0x10 unmapped, reads 0); all lines edge-triggered.
// TESTING
//  1 Reset: hold preset 2 cycles with irq_i=4'hF -> irq_o=0, PENDING reads 0 during reset.
//  2 Edge capture: MASK=4'h3, pulse irq_i[1] 1 cycle -> next cycle irq_o=1, irq_id_o=1,
//    PENDING=0x2, ID=0x8000_0001; write CLEAR=0x2 -> irq_o=0 next cycle.
//  3 Priority/mask: MASK=0xC, pulse irq_i[0] and irq_i[3] -> PENDING=0x9, irq_id_o=3;
//    write MASK=0xD -> irq_id_o=0 next cycle.
//  4 Simultaneous: CLEAR=0x1 write on the same edge irq_i[0] rises -> PENDING[0] stays 1.
//  5 Held level: irq_i[2] high 10 cycles in edge mode, CLEAR=0x4 at cycle 5 -> PENDING[2]=0
//    after clear, no re-pend until the next rising edge.
//  6 IRQ_CTRL_TYPE_EN: TYPE=0x4, irq_i[2] held high, CLEAR=0x4 -> PENDING[2]=1 next cycle;
//    without macro read 0x10 -> 0.

Source files
------------

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: sticky pending bits, per-line mask, fixed lowest-index priority.
// Define IRQ_CTRL_TYPE_EN to add the TYPE register (0x10) for per-line level-sensitive mode.
module apb_irq_ctrl #(
  parameter int IRQ_NUM = 4
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [31:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [IRQ_NUM-1:0] irq_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_MASK    = 3'd1,
    REG_CLEAR   = 3'd2,
    REG_ID      = 3'd3,
    REG_TYPE    = 3'd4
  } reg_sel_e;

  reg_sel_e           reg_sel;
  logic               wr_en;
  logic               rd_en;
  logic [IRQ_NUM-1:0] pending_q, pending_d;
  logic [IRQ_NUM-1:0] mask_q, mask_d;
  logic [IRQ_NUM-1:0] irq_prev_q;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] set;
  logic [IRQ_NUM-1:0] clr;
  logic [IRQ_NUM-1:0] active;
  logic [IRQ_NUM-1:0] level_mode;
  logic               unused_bits;

  assign reg_sel = reg_sel_e'(paddr[4:2]);
  assign wr_en   = psel & penable & pwrite;
  assign rd_en   = psel & penable & ~pwrite;
  assign pready  = 1'b1;
  assign pslverr = 1'b0;

  assign unused_bits = ^{paddr[31:5], paddr[1:0], pwdata};

`ifdef IRQ_CTRL_TYPE_EN
  logic [IRQ_NUM-1:0] type_q, type_d;
  assign level_mode = type_q;
`else
  assign level_mode = '0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
`ifdef IRQ_CTRL_TYPE_EN
    type_d = type_q;
`endif
    if (wr_en) begin
      case (reg_sel)
        REG_MASK:  mask_d = pwdata[IRQ_NUM-1:0];
        REG_CLEAR: clr    = pwdata[IRQ_NUM-1:0];
`ifdef IRQ_CTRL_TYPE_EN
        REG_TYPE:  type_d = pwdata[IRQ_NUM-1:0];
`endif
        default:   ;
      endcase
    end
  end

  // Set is ORed in after the clear so a same-cycle event is never lost.
  assign rise      = irq_i & ~irq_prev_q;
  assign set       = (level_mode & irq_i) | (~level_mode & rise);
  assign pending_d = (pending_q & ~clr) | set;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (preset) begin
      pending_q  <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
`ifdef IRQ_CTRL_TYPE_EN
      type_q     <= '0;
`endif
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_i;
`ifdef IRQ_CTRL_TYPE_EN
      type_q     <= type_d;
`endif
    end
  end

  assign active = pending_q & mask_q;
  assign irq_o  = |active;

  // Scanning downward leaves the lowest active index as the final assignment.
  always_comb begin
    irq_id_o = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (active[i]) irq_id_o = 5'(i);
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_PENDING: prdata = 32'(pending_q);
        REG_MASK:    prdata = 32'(mask_q);
        REG_ID:      prdata = {irq_o, 26'd0, irq_id_o};
`ifdef IRQ_CTRL_TYPE_EN
        REG_TYPE:    prdata = 32'(type_q);
`endif
        default:     prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Testbench for apb_irq_ctrl: vector table, directed corner sequences, randomized run vs. reference model.
module tb_apb_irq_ctrl;
  localparam int N = 4;
`ifdef IRQ_CTRL_TYPE_EN
  localparam bit TYPE_EN = 1'b1;
`else
  localparam bit TYPE_EN = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          preset, psel, penable, pwrite;
  logic [31:0]   paddr, pwdata, prdata;
  logic          pready, pslverr;
  logic [N-1:0]  irq_i;
  logic          irq_o;
  logic [4:0]    irq_id_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: one flag per line.
  bit pend_m[N];
  bit mask_m[N];
  bit prev_m[N];
  bit type_m[N];

  apb_irq_ctrl #(.IRQ_NUM(N)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq_i(irq_i), .irq_o(irq_o), .irq_id_o(irq_id_o)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit           s, e, w;
    logic [31:0]  addr, wdata;
    logic [N-1:0] irq;
    logic [31:0]  exp_rd;
    bit           exp_irq;
    logic [4:0]   exp_id;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit s, c, wr;
    int sel;
    sel = int'(paddr[4:2]);
    wr  = psel && penable && pwrite;
    for (int i = 0; i < N; i++) begin
      if (preset) begin
        pend_m[i] = 0; mask_m[i] = 0; prev_m[i] = 0; type_m[i] = 0;
      end else begin
        s = type_m[i] ? irq_i[i] : (irq_i[i] && !prev_m[i]);
        c = wr && sel == 2 && pwdata[i];
        pend_m[i] = (pend_m[i] && !c) || s;
        if (wr && sel == 1) mask_m[i] = pwdata[i];
        if (TYPE_EN && wr && sel == 4) type_m[i] = pwdata[i];
        prev_m[i] = irq_i[i];
      end
    end
  endtask

  function automatic bit m_irq();
    for (int i = 0; i < N; i++) if (pend_m[i] && mask_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] m_id();
    for (int i = 0; i < N; i++) if (pend_m[i] && mask_m[i]) return 5'(i);
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] r;
    r = '0;
    if (!(psel && penable && !pwrite)) return r;
    case (int'(paddr[4:2]))
      0: for (int i = 0; i < N; i++) r[i] = pend_m[i];
      1: for (int i = 0; i < N; i++) r[i] = mask_m[i];
      3: r = {m_irq(), 26'd0, m_id()};
      4: if (TYPE_EN) for (int i = 0; i < N; i++) r[i] = type_m[i];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
  endtask

  task automatic drive(input bit s, input bit e, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [N-1:0] irq);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d; irq_i = irq;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [N-1:0] irq);
    drive(1, 1, 1, a, d, irq);
  endtask

  task automatic rd(input logic [31:0] a, input logic [N-1:0] irq);
    drive(1, 1, 0, a, 32'd0, irq);
  endtask

  function automatic vec_t mk(bit s, bit e, bit w, logic [31:0] a, logic [31:0] d,
                              logic [N-1:0] irq, logic [31:0] rdv, bit iq, logic [4:0] id);
    vec_t v;
    v.s = s; v.e = e; v.w = w; v.addr = a; v.wdata = d; v.irq = irq;
    v.exp_rd = rdv; v.exp_irq = iq; v.exp_id = id;
    return v;
  endfunction

  initial begin
    logic [31:0] addrs[6];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};

    // Each row: inputs held for one cycle; expectations are pre-edge outputs.
    vecs.push_back(mk(1,1,1, 32'h04, 32'h3,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(0,0,0, 32'h00, 32'h0,        4'h2, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h00, 32'h0,        4'h0, 32'h2,         1, 5'd1));
    vecs.push_back(mk(1,1,0, 32'h0C, 32'h0,        4'h0, 32'h8000_0001, 1, 5'd1));
    vecs.push_back(mk(1,1,1, 32'h08, 32'h2,        4'h0, 32'h0,         1, 5'd1));
    vecs.push_back(mk(1,1,0, 32'h00, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,1, 32'h04, 32'hC,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(0,0,0, 32'h00, 32'h0,        4'h9, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h00, 32'h0,        4'h0, 32'h9,         1, 5'd3));
    vecs.push_back(mk(1,1,1, 32'h04, 32'hD,        4'h0, 32'h0,         1, 5'd3));
    vecs.push_back(mk(1,1,0, 32'h04, 32'h0,        4'h0, 32'hD,         1, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h0C, 32'h0,        4'h0, 32'h8000_0000, 1, 5'd0));
    vecs.push_back(mk(1,1,1, 32'h08, 32'hF,        4'h0, 32'h0,         1, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h00, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h10, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h14, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,0,1, 32'h04, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h04, 32'h0,        4'h0, 32'hD,         0, 5'd0));
    vecs.push_back(mk(1,0,0, 32'h04, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,1, 32'h04, 32'hFFFF_FFF0, 4'h0, 32'h0,        0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h04, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,1, 32'h14, 32'hF,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h04, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(0,0,0, 32'h00, 32'h0,        4'h1, 32'h0,         0, 5'd0));
    vecs.push_back(mk(0,0,0, 32'h00, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(0,0,0, 32'h00, 32'h0,        4'h1, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h00, 32'h0,        4'h0, 32'h1,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h08, 32'h0,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,1, 32'h08, 32'h1,        4'h0, 32'h0,         0, 5'd0));
    vecs.push_back(mk(1,1,0, 32'h00, 32'h0,        4'h0, 32'h0,         0, 5'd0));

    // Reset held with all lines high.
    preset = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'hF);
    @(negedge pclk);
    tick();
    for (int k = 0; k < 2; k++) begin
      rd(32'h00, 4'hF);
      check("reset_pending_rd", prdata, 32'h0);
      check("reset_irq_o", 32'(irq_o), 32'h0);
      check("reset_irq_id", 32'(irq_id_o), 32'h0);
      tick();
    end
    preset = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 4'hF);
    tick();
    rd(32'h00, 4'hF);
    check("post_reset_high_is_edge", prdata, 32'hF);
    check("post_reset_masked_irq", 32'(irq_o), 32'h0);
    check("pready", 32'(pready), 32'h1);
    check("pslverr", 32'(pslverr), 32'h0);
    tick();
    preset = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    preset = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].s, vecs[k].e, vecs[k].w, vecs[k].addr, vecs[k].wdata, vecs[k].irq);
      check($sformatf("vec%0d_prdata", k), prdata, vecs[k].exp_rd);
      check($sformatf("vec%0d_irq_o", k), 32'(irq_o), 32'(vecs[k].exp_irq));
      check($sformatf("vec%0d_irq_id", k), 32'(irq_id_o), 32'(vecs[k].exp_id));
      tick();
    end

    // Clear and set of the same bit on the same edge.
    wr(32'h08, 32'h1, 4'h1);
    tick();
    rd(32'h00, 4'h0);
    check("simul_set_wins", prdata, 32'h1);
    tick();
    wr(32'h08, 32'hF, 4'h0);
    tick();

    // Held level in edge mode: one pending event, no re-pend after clear.
    drive(0, 0, 0, 32'h0, 32'h0, 4'h4);
    tick();
    for (int k = 2; k <= 4; k++) begin
      rd(32'h00, 4'h4);
      check($sformatf("held_pend_c%0d", k), prdata, 32'h4);
      tick();
    end
    wr(32'h08, 32'h4, 4'h4);
    tick();
    for (int k = 6; k <= 10; k++) begin
      rd(32'h00, 4'h4);
      check($sformatf("held_cleared_c%0d", k), prdata, 32'h0);
      tick();
    end
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 4'h4);
    tick();
    rd(32'h00, 4'h4);
    check("held_new_edge", prdata, 32'h4);
    tick();

    // Unmasking an already pending line raises irq_o the following cycle.
    wr(32'h04, 32'h4, 4'h4);
    check("unmask_before", 32'(irq_o), 32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("unmask_irq_o", 32'(irq_o), 32'h1);
    check("unmask_irq_id", 32'(irq_id_o), 32'h2);
    tick();
    wr(32'h08, 32'hF, 4'h0);
    tick();

`ifdef IRQ_CTRL_TYPE_EN
    wr(32'h10, 32'h4, 4'h4);
    tick();
    wr(32'h08, 32'h4, 4'h4);
    tick();
    rd(32'h00, 4'h4);
    check("level_repend", prdata, 32'h4);
    tick();
    rd(32'h10, 4'h0);
    check("type_readback", prdata, 32'h4);
    tick();
`else
    wr(32'h10, 32'hF, 4'h0);
    tick();
    rd(32'h10, 4'h0);
    check("type_unmapped", prdata, 32'h0);
    tick();
`endif

    // Randomized run against the reference model, starting from reset.
    preset = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    preset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] irq_n;
      preset = ($urandom_range(0, 63) == 0);
      irq_n  = ($urandom_range(0, 3) == 0) ? irq_i : N'($urandom & $urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            addrs[$urandom_range(0, 5)], $urandom, irq_n);
      check("rnd_prdata", prdata, m_rdata());
      check("rnd_irq_o", 32'(irq_o), 32'(m_irq()));
      check("rnd_irq_id", 32'(irq_id_o), 32'(m_id()));
      tick();
    end
    preset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
